// File: rtl/fu_bru_q_pkg.sv
// Shared definitions for the branch resolution unit: op encoding, link offset,
// queued uop layout and the priority decode of the one-hot op field.
package fu_bru_q_pkg;

  localparam int unsigned BRU_OP_W = 12;

  localparam int unsigned BRU_BEQ    = 11;
  localparam int unsigned BRU_BNE    = 10;
  localparam int unsigned BRU_BGEZ   = 9;
  localparam int unsigned BRU_BGTZ   = 8;
  localparam int unsigned BRU_BLEZ   = 7;
  localparam int unsigned BRU_BLTZ   = 6;
  localparam int unsigned BRU_BGEZAL = 5;
  localparam int unsigned BRU_BLTZAL = 4;
  localparam int unsigned BRU_J      = 3;
  localparam int unsigned BRU_JAL    = 2;
  localparam int unsigned BRU_JR     = 1;
  localparam int unsigned BRU_JALR   = 0;

  localparam logic [31:0] BRU_LINK_OFS = 32'h8;
  localparam logic [31:0] BRU_SEQ_OFS  = 32'h4;

  typedef enum logic [3:0] {
    KIND_NONE,
    KIND_BEQ,
    KIND_BNE,
    KIND_BGEZ,
    KIND_BGTZ,
    KIND_BLEZ,
    KIND_BLTZ,
    KIND_BGEZAL,
    KIND_BLTZAL,
    KIND_J,
    KIND_JAL,
    KIND_JR,
    KIND_JALR
  } bru_kind_e;

  typedef struct packed {
    logic [BRU_OP_W-1:0] op;
    logic [31:0]         pc;
    logic [31:0]         imm;
    logic [31:0]         rs;
    logic [31:0]         rt;
    logic                we;
    logic                pred_taken;
    logic [31:0]         pred_target;
  } bru_uop_t;

  // Multi-hot ops resolve to the highest-priority bit, beq first.
  function automatic bru_kind_e bru_decode(input logic [BRU_OP_W-1:0] op);
    if (op[BRU_BEQ])         return KIND_BEQ;
    else if (op[BRU_BNE])    return KIND_BNE;
    else if (op[BRU_BGEZ])   return KIND_BGEZ;
    else if (op[BRU_BGTZ])   return KIND_BGTZ;
    else if (op[BRU_BLEZ])   return KIND_BLEZ;
    else if (op[BRU_BLTZ])   return KIND_BLTZ;
    else if (op[BRU_BGEZAL]) return KIND_BGEZAL;
    else if (op[BRU_BLTZAL]) return KIND_BLTZAL;
    else if (op[BRU_J])      return KIND_J;
    else if (op[BRU_JAL])    return KIND_JAL;
    else if (op[BRU_JR])     return KIND_JR;
    else if (op[BRU_JALR])   return KIND_JALR;
    return KIND_NONE;
  endfunction

endpackage

// File: rtl/fu_bru_q_if.sv
// Dispatch-side uop offer and commit-side resolved result of the branch unit.
interface fu_bru_q_if
  import fu_bru_q_pkg::*;
#(
  parameter int unsigned TAG_W = 5
);

  logic                in_valid;
  logic                in_ready;
  logic [BRU_OP_W-1:0] in_op;
  logic [TAG_W-1:0]    in_tag;
  logic [31:0]         in_pc;
  logic [31:0]         in_imm;
  logic                in_we;
  logic [31:0]         in_rdata1;
  logic [31:0]         in_rdata2;
  logic                in_pred_taken;
  logic [31:0]         in_pred_target;

  logic                out_valid;
  logic                out_ready;
  logic [TAG_W-1:0]    out_tag;
  logic                out_cb_we;
  logic                out_rf_we;
  logic [31:0]         out_wdata;
  logic                out_br_e;
  logic [31:0]         out_target;
  logic                out_mispredict;

  modport master (
    output in_valid, in_op, in_tag, in_pc, in_imm, in_we,
           in_rdata1, in_rdata2, in_pred_taken, in_pred_target,
    input  in_ready,
    input  out_valid, out_tag, out_cb_we, out_rf_we, out_wdata,
           out_br_e, out_target, out_mispredict,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_tag, in_pc, in_imm, in_we,
           in_rdata1, in_rdata2, in_pred_taken, in_pred_target,
    output in_ready,
    output out_valid, out_tag, out_cb_we, out_rf_we, out_wdata,
           out_br_e, out_target, out_mispredict,
    input  out_ready
  );

endinterface

// File: rtl/bru_queue.sv
// In-order issue queue: synchronous FIFO with a clear that empties it at the edge.
// Pointers carry a wrap bit so full and empty are told apart without a counter.
module bru_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fu_bru_q.sv
// Branch resolution unit: queued branch/jump uops are resolved one per cycle at the
// queue head into a handshaked result register, with mispredict redirect and stats.
module fu_bru_q
  import fu_bru_q_pkg::*;
#(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  fu_bru_q_if.slave        bus,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_mispred
);

  localparam int unsigned QW = TAG_W + $bits(bru_uop_t);

  bru_uop_t         in_uop;
  bru_uop_t         head;
  logic [TAG_W-1:0] head_tag;
  logic [QW-1:0]    q_dout;
  logic             q_full;
  logic             q_empty;
  logic             push;
  logic             load;
  logic             clear;
  logic             redirect_now;

  bru_kind_e        kind;
  logic             eq, ge, gt, le, lt;
  logic             taken;
  logic             link;
  logic [31:0]      br_target;
  logic [31:0]      link_pc;
  logic [31:0]      target;
  logic             mispredict;

  always_comb begin
    in_uop             = '0;
    in_uop.op          = bus.in_op;
    in_uop.pc          = bus.in_pc;
    in_uop.imm         = bus.in_imm;
    in_uop.rs          = bus.in_rdata1;
    in_uop.rt          = bus.in_rdata2;
    in_uop.we          = bus.in_we;
    in_uop.pred_taken  = bus.in_pred_taken;
    in_uop.pred_target = bus.in_pred_target;
  end

  assign {head_tag, head} = q_dout;

  // A mispredict load and a flush both empty the queue; the push of that cycle is lost.
  assign load         = !q_empty && (!bus.out_valid || bus.out_ready) && !flush;
  assign redirect_now = load && mispredict;
  assign clear        = flush || redirect_now;
  assign push         = bus.in_valid && !q_full && !clear;
  assign bus.in_ready = !q_full;

  bru_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .push   (push),
    .pop    (load),
    .din    ({bus.in_tag, in_uop}),
    .dout   (q_dout),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_comb begin
    kind      = bru_decode(head.op);
    eq        = (head.rs == head.rt);
    ge        = !head.rs[31];
    gt        = !head.rs[31] && (head.rs != '0);
    le        = head.rs[31] || (head.rs == '0);
    lt        = head.rs[31];
    br_target = head.pc + BRU_SEQ_OFS + head.imm;
    link_pc   = head.pc + BRU_LINK_OFS;
    taken     = 1'b0;
    link      = 1'b0;
    target    = br_target;
    case (kind)
      KIND_NONE:   target = '0;
      KIND_BEQ:    taken = eq;
      KIND_BNE:    taken = !eq;
      KIND_BGEZ:   taken = ge;
      KIND_BGTZ:   taken = gt;
      KIND_BLEZ:   taken = le;
      KIND_BLTZ:   taken = lt;
      KIND_BGEZAL: begin taken = ge; link = 1'b1; end
      KIND_BLTZAL: begin taken = lt; link = 1'b1; end
      KIND_J:      begin taken = 1'b1; target = head.imm; end
      KIND_JAL:    begin taken = 1'b1; target = head.imm; link = 1'b1; end
      KIND_JR:     begin taken = 1'b1; target = head.rs; end
      KIND_JALR:   begin taken = 1'b1; target = head.rs; link = 1'b1; end
      default:     target = '0;
    endcase
    mispredict = (kind != KIND_NONE) &&
                 ((taken != head.pred_taken) || (taken && (target != head.pred_target)));
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      bus.out_valid      <= 1'b0;
      bus.out_tag        <= '0;
      bus.out_cb_we      <= 1'b0;
      bus.out_rf_we      <= 1'b0;
      bus.out_wdata      <= '0;
      bus.out_br_e       <= 1'b0;
      bus.out_target     <= '0;
      bus.out_mispredict <= 1'b0;
    end else if (load) begin
      bus.out_valid      <= 1'b1;
      bus.out_tag        <= head_tag;
      bus.out_cb_we      <= |head.op;
      bus.out_rf_we      <= head.we;
      bus.out_wdata      <= link ? link_pc : '0;
      bus.out_br_e       <= taken;
      bus.out_target     <= target;
      bus.out_mispredict <= mispredict;
    end else if (bus.out_ready) begin
      bus.out_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= redirect_now;
      if (redirect_now) redirect_pc <= taken ? target : link_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_branch  <= '0;
      cnt_mispred <= '0;
    end else if (load) begin
      if ((kind != KIND_NONE) && (cnt_branch != '1)) cnt_branch <= cnt_branch + CNT_W'(1);
      if (mispredict && (cnt_mispred != '1)) cnt_mispred <= cnt_mispred + CNT_W'(1);
    end
  end

endmodule
